// File: rtl/demo_round_tracker_if.sv
// Event/status bundle between the A/B/C/D event source and the round tracker.
// The source drives the event pulses and clear; the tracker drives status.
// expect_idx carries the "next expected phase" field; the plain word expect
// is a reserved SystemVerilog keyword and cannot be used as a signal name.
interface demo_round_tracker_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             clear;
  logic [1:0]       expect_idx;
  logic             busy;
  logic             round_done;
  logic [CNT_W-1:0] round_count;
  logic [GAP_W-1:0] gap_len;
  logic             err_order;
  logic             err_multi;
  logic             err_timeout;

  modport master (
    output A, B, C, D, clear,
    input  expect_idx, busy, round_done, round_count, gap_len,
           err_order, err_multi, err_timeout
  );

  modport slave (
    input  A, B, C, D, clear,
    output expect_idx, busy, round_done, round_count, gap_len,
           err_order, err_multi, err_timeout
  );
endinterface

// File: rtl/demo_round_tracker.sv
// Round tracker: locks onto the rotating A->B->C->D->A event sequence,
// counts completed rounds (saturating), records the idle gap before each
// accepted event and latches sticky order / multi-hot / timeout errors.
module demo_round_tracker #(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8,
  parameter int MAX_GAP = 200
) (
  input  logic                 clock,
  input  logic                 reset_n,
  demo_round_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Last idle count that is still legal; one more idle cycle times out.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       ev_vec;
  logic             ev_any;
  logic             ev_single;
  logic [1:0]       ev_idx;

  assign ev_vec    = {bus.D, bus.C, bus.B, bus.A};
  assign ev_any    = |ev_vec;
  assign ev_single = ev_any && ((ev_vec & (ev_vec - 4'd1)) == 4'd0);

  // Phase index of a one-hot event; only meaningful when ev_single is high.
  always_comb begin
    ev_idx = 2'd0;
    case (ev_vec)
      4'b0010: ev_idx = 2'd1;
      4'b0100: ev_idx = 2'd2;
      4'b1000: ev_idx = 2'd3;
      default: ev_idx = 2'd0;
    endcase
  end

  // Sequence state machine with registered status outputs; clear beats any event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      bus.expect_idx  <= 2'd0;
      bus.busy        <= 1'b0;
      bus.round_done  <= 1'b0;
      bus.round_count <= '0;
      bus.gap_len     <= '0;
      bus.err_order   <= 1'b0;
      bus.err_multi   <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else if (bus.clear) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      bus.expect_idx  <= 2'd0;
      bus.busy        <= 1'b0;
      bus.round_done  <= 1'b0;
      bus.round_count <= '0;
      bus.gap_len     <= '0;
      bus.err_order   <= 1'b0;
      bus.err_multi   <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.round_done <= 1'b0;
      case (state)
        IDLE: begin
          // Only a lone A locks on; everything else is ignored while unlocked.
          if (ev_vec == 4'b0001) begin
            state          <= RUN;
            bus.busy       <= 1'b1;
            bus.expect_idx <= 2'd1;
            gap_cnt        <= '0;
            bus.gap_len    <= '0;
          end
        end
        RUN: begin
          if (!ev_any) begin
            if (gap_cnt == GAP_LAST) begin
              bus.err_timeout <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= ERR;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else if (!ev_single) begin
            bus.err_multi <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= ERR;
          end else if (ev_idx != bus.expect_idx) begin
            bus.err_order <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= ERR;
          end else begin
            bus.gap_len    <= gap_cnt;
            gap_cnt        <= '0;
            bus.expect_idx <= bus.expect_idx + 2'd1;
            // A closing A finishes one round and opens the next.
            if (ev_idx == 2'd0) begin
              bus.round_done  <= 1'b1;
              bus.round_count <= sat_inc(bus.round_count);
            end
          end
        end
        default: begin
          // ERR: frozen until clear or reset.
        end
      endcase
    end
  end

endmodule

// File: doc/demo_round_tracker.md
Name: demo_round_tracker

Overview:
Downstream monitor/consumer of the demo block's A/B/C/D event outputs. Locks onto the rotating A->B->C->D->A sequence, counts completed rounds, and measures inter-event gaps. It latches sticky errors for out-of-order events, simultaneous events and gap timeouts. Its outputs feed status registers and give simulation and formal benches a synthesizable view of sequence health.

Parameters:
CNT_W, 16, width of round_count; saturates at all-ones.
GAP_W, 8, width of the gap counter and gap_len.
MAX_GAP, 200, idle cycles allowed between accepted events before timeout; legal range 1 .. 2^GAP_W-1.

Ports:
clock  in  1  single clock, all state on posedge.
reset_n  in  1  asynchronous, active-low reset.
A  in  1  phase-0 event pulse.
B  in  1  phase-1 event pulse.
C  in  1  phase-2 event pulse.
D  in  1  phase-3 event pulse.
clear  in  1  synchronous clear; returns to IDLE and clears counters and errors.
expect  out  2  index of the next expected phase (0=A, 1=B, 2=C, 3=D).
busy  out  1  high while in RUN.
round_done  out  1  one-cycle pulse when a round closes.
round_count  out  CNT_W  completed rounds, saturating.
gap_len  out  GAP_W  idle cycles before the most recently accepted event.
err_order  out  1  sticky; a single event arrived that did not match expect.
err_multi  out  1  sticky; two or more of A..D were high in one cycle.
err_timeout  out  1  sticky; MAX_GAP consecutive idle cycles occurred in RUN.

Behaviour:
- Reset (reset_n low, async): state=IDLE, expect=0, busy=0, round_done=0, round_count=0, gap_len=0, internal gap_cnt=0, all err_* = 0.
- All outputs are registered. Response appears the cycle after the sampled input.
- Definitions: ev = A|B|C|D. A cycle is "single" when exactly one of A..D is high; its index is that input's phase.
- States: IDLE, RUN, ERR.
- IDLE:
  - A single A -> RUN, expect=1, gap_cnt=0, gap_len=0.
  - Any other input pattern, including multi-hot, is ignored. No error is raised while unlocked.
- RUN, single event with index == expect:
  - Accept it: gap_len <= gap_cnt, gap_cnt <= 0, expect <= expect+1 mod 4.
  - If the index is 0 (closing A): round_done=1 and round_count increments, holding at all-ones. The closing A also opens the next round.
- RUN, single event with index != expect: err_order=1 -> ERR.
- RUN, multi-hot event: err_multi=1 -> ERR. err_order is not also set.
- RUN, no event:
  - If gap_cnt == MAX_GAP-1: err_timeout=1 -> ERR. This fires on the MAX_GAP-th consecutive idle cycle.
  - Otherwise gap_cnt increments.
- ERR: all inputs except clear are ignored. Errors and counters hold. busy=0. expect holds its last value.
- clear (any state): next state IDLE, expect=0, round_count=0, gap_cnt=0, gap_len=0, all err_* = 0, round_done=0.
  - clear has priority over a same-cycle event; that event is dropped, including an A.
- round_done is 0 in every cycle not described above.
- Only one err_* bit can be set per ERR entry. Once a bit is set it holds until clear or reset.
- Reset asserted mid-round: everything returns immediately to reset values, with no partial-round count.
- Expected RTL size is about 150-250 lines: state register, one-hot decode, gap counter, output registers.

Test Plan:
1. Reset, then A, B, C, D, A on consecutive cycles -> busy=1 after the first A; expect steps 1,2,3,0,1; round_done pulses once, one cycle after the second A; round_count=1; gap_len=0.
2. A, 3 idle cycles, B, 5 idle cycles, C -> gap_len=3 after B and 5 after C; no errors; expect=3.
3. A, B, then D -> err_order=1, state ERR, busy=0; a later C, D, A has no effect and round_count is unchanged. Then clear -> all errors 0, expect=0, IDLE.
4. A, then B and C high together -> err_multi=1, err_order=0. Separately, in IDLE, B and C high together -> no error and state stays IDLE.
5. MAX_GAP=4: A followed by 3 idle cycles then B -> accepted with gap_len=3. A followed by 4 idle cycles -> err_timeout=1 on the 4th idle cycle.
6. CNT_W=2: run 5 full rounds -> round_count goes 1,2,3,3,3. Then clear in the same cycle as an A -> IDLE, round_count=0, that A is not accepted, and busy stays 0. Also assert reset_n mid-round -> immediate return to reset values.
